// File: rtl/warp_issue_scheduler_if.sv
// Issue-slot handshake between the warp scheduler and the execute/LSU stage.
// The master side (scheduler) presents one instruction and holds it until issue_ready.
interface warp_issue_scheduler_if #(
    parameter int unsigned NUM_WARPS = 4
);
    localparam int unsigned WARP_W = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;

    logic              issue_valid;
    logic              issue_ready;
    logic [WARP_W-1:0] issue_warp;
    logic [3:0]        issue_mask_enc;
    logic              issue_is_mem;

    modport master (
        output issue_valid,
        output issue_warp,
        output issue_mask_enc,
        output issue_is_mem,
        input  issue_ready
    );

    modport slave (
        input  issue_valid,
        input  issue_warp,
        input  issue_mask_enc,
        input  issue_is_mem,
        output issue_ready
    );
endinterface

// File: rtl/warp_issue_scheduler.sv
// Round-robin warp issue scheduler gated by the per-thread scoreboard.
// Memory issues set the scoreboard in the handshake cycle so the next selection sees them.
module warp_issue_scheduler #(
    parameter int unsigned NUM_WARPS        = 4,
    parameter int unsigned THREADS_PER_WARP = 8,
    parameter int unsigned NUM_THREADS      = NUM_WARPS * THREADS_PER_WARP,
    parameter int unsigned STALL_CNT_W      = 16,
    localparam int unsigned WARP_W          = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_WARPS-1:0]   inst_valid,
    input  logic [NUM_WARPS-1:0]   inst_is_mem,
    input  logic [NUM_WARPS*4-1:0] inst_mask_enc,
    input  logic [NUM_THREADS-1:0] inst_threads,
    output logic [NUM_WARPS-1:0]   inst_pop,
    input  logic [NUM_THREADS-1:0] busy_threads,
    warp_issue_scheduler_if.master issue,
    output logic                   busy_en,
    output logic [WARP_W-1:0]      warp_num_busy,
    output logic [3:0]             threads_mask_busy,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    typedef enum logic [0:0] {StSelect, StIssue} state_e;

    state_e                 state_q;
    logic [WARP_W-1:0]      rr_ptr_q;
    logic                   valid_q;
    logic [WARP_W-1:0]      warp_q;
    logic [3:0]             mask_q;
    logic                   mem_q;
    logic [STALL_CNT_W-1:0] stall_q;

    logic [NUM_WARPS-1:0]   eligible;
    logic                   found;
    logic [WARP_W-1:0]      pick;
    logic [WARP_W-1:0]      cand;
    logic                   handshake;

    always_comb begin
        eligible = '0;
        for (int w = 0; w < int'(NUM_WARPS); w++) begin
            eligible[w] = inst_valid[w] &&
                ((inst_threads[w*THREADS_PER_WARP +: THREADS_PER_WARP] &
                  busy_threads[w*THREADS_PER_WARP +: THREADS_PER_WARP]) == '0);
        end
    end

    // Search rr_ptr+1 .. rr_ptr+NUM_WARPS; the last candidate wraps back to rr_ptr itself.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int i = 1; i <= int'(NUM_WARPS); i++) begin
            cand = rr_ptr_q + WARP_W'(i);
            if (!found && eligible[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StSelect;
            rr_ptr_q <= WARP_W'(NUM_WARPS - 1);
            valid_q  <= 1'b0;
            warp_q   <= '0;
            mask_q   <= '0;
            mem_q    <= 1'b0;
            stall_q  <= '0;
        end else begin
            case (state_q)
                StSelect: begin
                    if (found) begin
                        warp_q  <= pick;
                        mask_q  <= inst_mask_enc[pick*4 +: 4];
                        mem_q   <= inst_is_mem[pick];
                        valid_q <= 1'b1;
                        state_q <= StIssue;
                    end else if ((inst_valid != '0) && (stall_q != '1)) begin
                        stall_q <= stall_q + 1'b1;
                    end
                end
                StIssue: begin
                    if (issue.issue_ready) begin
                        valid_q  <= 1'b0;
                        rr_ptr_q <= warp_q;
                        state_q  <= StSelect;
                    end
                end
                default: state_q <= StSelect;
            endcase
        end
    end

    assign handshake = valid_q && issue.issue_ready;

    always_comb begin
        inst_pop = '0;
        if (handshake) begin
            inst_pop[warp_q] = 1'b1;
        end
    end

    assign busy_en           = handshake && mem_q;
    assign warp_num_busy     = busy_en ? warp_q : '0;
    assign threads_mask_busy = busy_en ? mask_q : '0;

    assign issue.issue_valid    = valid_q;
    assign issue.issue_warp     = warp_q;
    assign issue.issue_mask_enc = mask_q;
    assign issue.issue_is_mem   = mem_q;
    assign stall_cycles         = stall_q;

endmodule

// File: doc/warp_issue_scheduler.md
Name: warp_issue_scheduler

Overview:
- Picks one ready warp per issue slot, round-robin among NUM_WARPS warps, and presents its instruction to the execute/LSU stage over a valid/ready handshake.
- Gates issue on the scoreboard: a warp cannot issue while any of its active threads are marked busy.
- On every memory issue, drives the scoreboard set port (busy_en, warp_num_busy, threads_mask_busy).
- Sits between per-warp instruction buffers and the execute/LSU stage. The LSU owns the scoreboard clear port.

Parameters:
NUM_WARPS, 4, warp count; power of two.
THREADS_PER_WARP, 8, threads per warp.
NUM_THREADS, 32, NUM_WARPS*THREADS_PER_WARP; must match the scoreboard.
STALL_CNT_W, 16, width of the stall counter.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-low reset.
inst_valid  in  NUM_WARPS  per-warp instruction buffer holds a valid instruction; held until popped.
inst_is_mem  in  NUM_WARPS  per-warp: instruction is a memory op.
inst_mask_enc  in  NUM_WARPS*4  per-warp 4-bit encoded thread mask, scoreboard encoding; warp w at bits [4w+3:4w].
inst_threads  in  NUM_THREADS  per-warp decoded active threads; warp w at bits [8w+7:8w].
inst_pop  out  NUM_WARPS  one-hot, one-cycle pop of the issued warp's buffer.
busy_threads  in  NUM_THREADS  scoreboard busy vector.
issue_valid  out  1  issue slot holds an instruction.
issue_ready  in  1  downstream accepts.
issue_warp  out  log2(NUM_WARPS)  warp id of the issued instruction.
issue_mask_enc  out  4  encoded mask of the issued instruction.
issue_is_mem  out  1  issued instruction is a memory op.
busy_en  out  1  scoreboard set strobe.
warp_num_busy  out  log2(NUM_WARPS)  scoreboard set warp.
threads_mask_busy  out  4  scoreboard set mask.
stall_cycles  out  STALL_CNT_W  saturating count of hazard-stall cycles.

Behaviour:
- Reset (async, reset=0), all of the following are forced immediately:
  - state=SELECT; rr_ptr=NUM_WARPS-1.
  - issue_valid=0, issue_warp=0, issue_mask_enc=0, issue_is_mem=0.
  - inst_pop=0, busy_en=0, warp_num_busy=0, threads_mask_busy=0, stall_cycles=0.
  - Reset mid-handshake discards the held instruction; no pop and no busy_en is produced.
- Eligibility: eligible[w] = inst_valid[w] && ((inst_threads[w] & busy_threads[w]) == 0).
  - Applies to all instructions, memory or not.
  - An all-zero thread mask is eligible.
- FSM, two states:
  - SELECT:
    - If any warp is eligible: choose the first eligible warp searching rr_ptr+1, rr_ptr+2, ... modulo NUM_WARPS.
    - Register issue_warp, issue_mask_enc and issue_is_mem from the chosen warp; next state ISSUE.
    - If none is eligible and inst_valid != 0: stall_cycles increments, saturating at all-ones.
    - If inst_valid == 0: idle, no count.
  - ISSUE:
    - issue_valid=1; outputs are stable until the handshake.
    - On issue_valid && issue_ready, all in the same cycle:
      - inst_pop[issue_warp]=1.
      - If issue_is_mem: busy_en=1, warp_num_busy=issue_warp, threads_mask_busy=issue_mask_enc.
      - rr_ptr <= issue_warp; next state SELECT.
    - Without issue_ready: hold. issue_valid is never withdrawn.
- inst_pop and busy_en are combinational from the ISSUE-state handshake. Both are one-cycle pulses and are 0 at all other times.
- Throughput: one issue per 2 cycles maximum (SELECT, then ISSUE with ready=1).
- Latency: 1 cycle from an eligible warp in SELECT to issue_valid.
- Scoreboard timing: the scoreboard set takes effect at the handshake edge, so the next SELECT cycle sees the updated busy_threads. A dependent instruction from the same warp therefore never slips through.
- Simultaneous scoreboard clear and set on the same warp: the scheduler does not arbitrate this; the scoreboard resolves it.
- Changes to busy_threads while in ISSUE do not affect the held instruction.
- Upstream contract: inst_valid, inst_is_mem, inst_mask_enc and inst_threads stay stable for a warp until inst_pop for that warp.
- Wrap-around: rr_ptr=NUM_WARPS-1 searches starting from warp 0.

Test Plan:
1. Reset release, inst_valid=4'b1111, busy_threads=0, issue_ready=1 -> issue order warps 0,1,2,3,0, one issue every 2 cycles; inst_pop one-hot matches issue_warp.
2. Warp 1 memory op, inst_mask_enc=4'hA, ready=1 -> busy_en=1, warp_num_busy=1, threads_mask_busy=4'hA in the handshake cycle only; non-mem issue -> busy_en stays 0.
3. busy_threads=32'h0000_FF00, inst_valid=4'b0010 (warp 1 threads 8'hFF) -> no issue; stall_cycles counts 1,2,3,...; drop busy to 0 -> warp 1 issues the next cycle.
4. busy_threads bits [9:8] set, warp 1 inst_threads=8'hF0 -> no overlap, warp 1 issues immediately.
5. issue_ready=0 for 5 cycles in ISSUE -> issue_valid stays 1, outputs unchanged, no pop/busy_en; ready=1 -> single pop.
6. Assert reset=0 mid-ISSUE -> issue_valid=0 and stall_cycles=0 with no clock edge; after release, first issue is warp 0.
